serial_addsub_lanes: RTL and testbench



---
 rtl/serial_addsub_lanes.sv | 101 ++++++++++
 tb/tb_serial_addsub_lanes.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_lanes.sv
// Digit-serial add/subtract over LANES parallel lanes, LSB digit first, with word framing.
// Define SERIAL_ADDSUB_LANES_ERR_EN to add a sticky protocol-error output 'err'.
module serial_addsub_lanes #(
  parameter int DIGIT_W = 1,
  parameter int LANES   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic                       sub,
  input  logic [LANES*DIGIT_W-1:0]   a,
  input  logic [LANES*DIGIT_W-1:0]   b,
  output logic                       out_valid,
  output logic                       out_first,
  output logic                       out_last,
  output logic [LANES*DIGIT_W-1:0]   out_sum,
  output logic [LANES-1:0]           out_carry,
  output logic [LANES-1:0]           out_ovf
`ifdef SERIAL_ADDSUB_LANES_ERR_EN
  ,
  output logic                       err
`endif
);

  logic                     in_frame;
  logic                     sub_q;
  logic [LANES-1:0]         carry_q;

  logic                     accept;
  logic                     sub_eff;
  logic [LANES*DIGIT_W-1:0] sum_c;
  logic [LANES-1:0]         cout_c;
  logic [LANES-1:0]         ovf_c;

  // A word must open with in_first; a new in_first always restarts with fresh carry and mode.
  always_comb begin
    accept  = in_valid & (in_first | in_frame);
    sub_eff = in_first ? sub : sub_q;
    sum_c   = '0;
    cout_c  = '0;
    ovf_c   = '0;
    for (int l = 0; l < LANES; l++) begin : lane_math
      logic [DIGIT_W-1:0] a_l;
      logic [DIGIT_W-1:0] b_eff;
      logic               cin;
      logic [DIGIT_W:0]   full;
      a_l   = a[l*DIGIT_W +: DIGIT_W];
      b_eff = sub_eff ? ~b[l*DIGIT_W +: DIGIT_W] : b[l*DIGIT_W +: DIGIT_W];
      cin   = in_first ? sub_eff : carry_q[l];
      full  = {1'b0, a_l} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
      sum_c[l*DIGIT_W +: DIGIT_W] = full[DIGIT_W-1:0];
      cout_c[l] = full[DIGIT_W];
      // Carry into the top bit recovered from the sum bit, then XORed with carry out.
      ovf_c[l]  = full[DIGIT_W-1] ^ a_l[DIGIT_W-1] ^ b_eff[DIGIT_W-1] ^ full[DIGIT_W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_frame  <= 1'b0;
      sub_q     <= 1'b0;
      carry_q   <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_sum   <= '0;
      out_carry <= '0;
      out_ovf   <= '0;
    end else if (accept) begin
      carry_q   <= cout_c;
      in_frame  <= ~in_last;
      if (in_first)
        sub_q <= sub;
      out_valid <= 1'b1;
      out_first <= in_first;
      out_last  <= in_last;
      out_sum   <= sum_c;
      out_carry <= {LANES{in_last}} & cout_c;
      out_ovf   <= {LANES{in_last}} & ovf_c;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef SERIAL_ADDSUB_LANES_ERR_EN
  logic proto_err;

  // Missing first (orphan digit) or missing last (first while a word is open).
  assign proto_err = in_valid & (in_first ? in_frame : ~in_frame);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err <= 1'b0;
    else if (proto_err)
      err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_serial_addsub_lanes.sv
// Scoreboard bench for serial_addsub_lanes (DIGIT_W=4, LANES=2) against a word-level arithmetic model.
module tb_serial_addsub_lanes;

  localparam int D = 4;
  localparam int L = 2;
  localparam int W = D * L;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         out_valid, out_first, out_last;
  logic [W-1:0] out_sum;
  logic [L-1:0] out_carry, out_ovf;
`ifdef SERIAL_ADDSUB_LANES_ERR_EN
  logic         err;
`endif

  serial_addsub_lanes #(.DIGIT_W(D), .LANES(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .sub(sub), .a(a), .b(b), .out_valid(out_valid), .out_first(out_first),
    .out_last(out_last), .out_sum(out_sum), .out_carry(out_carry), .out_ovf(out_ovf)
`ifdef SERIAL_ADDSUB_LANES_ERR_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         first;
    logic         last;
    logic [L-1:0] carry;
    logic [L-1:0] ovf;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   last_out;
  int     checks = 0;
  int     fails  = 0;

  // Word-level model: accumulated operand values per lane, digit count, mode.
  bit     m_frame = 0;
  bit     m_sub   = 0;
  int     m_k     = 0;
  longint m_a[L];
  longint m_b[L];
  bit     err_exp = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit v, input bit f, input bit l, input bit s,
                            input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t   e;
    longint n, mask, half, res, sa, sb, rs;
    if (!v) return;
    if (!f && !m_frame) begin
      err_exp = 1;
      return;
    end
    if (f) begin
      if (m_frame) err_exp = 1;
      m_sub = s;
      m_k   = 0;
      for (int i = 0; i < L; i++) begin
        m_a[i] = 0;
        m_b[i] = 0;
      end
    end
    e.first = f;
    e.last  = l;
    e.sum   = '0;
    e.carry = '0;
    e.ovf   = '0;
    n    = longint'((m_k + 1) * D);
    mask = (longint'(1) << n) - 1;
    half = longint'(1) << (n - 1);
    for (int i = 0; i < L; i++) begin
      m_a[i] = m_a[i] + (longint'(av[i*D +: D]) << (m_k * D));
      m_b[i] = m_b[i] + (longint'(bv[i*D +: D]) << (m_k * D));
      res = (m_sub ? (m_a[i] - m_b[i]) : (m_a[i] + m_b[i])) & mask;
      e.sum[i*D +: D] = D'(res >> (m_k * D));
      if (l) begin
        e.carry[i] = m_sub ? (m_a[i] >= m_b[i]) : (((m_a[i] + m_b[i]) >> n) != 0);
        sa = (m_a[i] ^ half) - half;
        sb = (m_b[i] ^ half) - half;
        rs = m_sub ? (sa - sb) : (sa + sb);
        e.ovf[i] = (rs < -half) || (rs >= half);
      end
    end
    m_frame = !l;
    m_k++;
    exp_q.push_back(e);
  endtask

  task automatic apply_stimulus(input bit v, input bit f, input bit l, input bit s,
                                input logic [W-1:0] av, input logic [W-1:0] bv);
    @(posedge clk);
    #1;
    in_valid = v;
    in_first = f;
    in_last  = l;
    sub      = s;
    a        = av;
    b        = bv;
    model_step(v, f, l, s, av, bv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, W'($urandom), W'($urandom));
  endtask

  task automatic check_err();
    @(negedge clk);
`ifdef SERIAL_ADDSUB_LANES_ERR_EN
    check_output("err", {63'd0, err}, {63'd0, err_exp});
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    check_output({tag, "_sum"}, {56'd0, out_sum}, 64'd0);
    check_output({tag, "_flags"}, {58'd0, out_first, out_last, out_carry, out_ovf}, 64'd0);
  endtask

  // Monitor: pops one expectation per presented digit; otherwise outputs must hold.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_output("spurious_valid", 64'd1, 64'd0);
        end else begin
          last_out = exp_q.pop_front();
          check_output("sum", {56'd0, out_sum}, {56'd0, last_out.sum});
          check_output("first_last", {62'd0, out_first, out_last}, {62'd0, last_out.first, last_out.last});
          check_output("carry", {62'd0, out_carry}, {62'd0, last_out.carry});
          check_output("ovf", {62'd0, out_ovf}, {62'd0, last_out.ovf});
        end
      end else begin
        check_output("hold_sum", {56'd0, out_sum}, {56'd0, last_out.sum});
        check_output("hold_flags", {58'd0, out_first, out_last, out_carry, out_ovf},
                     {58'd0, last_out.first, last_out.last, last_out.carry, last_out.ovf});
      end
    end
  end

  initial begin
    logic [W-1:0] wa[4];
    logic [W-1:0] wb[4];
    last_out = '{default: '0};
    #12;
    check_reset_outputs("reset");
`ifdef SERIAL_ADDSUB_LANES_ERR_EN
    check_output("err_reset", {63'd0, err}, 64'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;

    // lane0 0xFF+0x01, lane1 0x7F+0x01 as two-digit words
    apply_stimulus(1, 1, 0, 0, 8'hFF, 8'h11);
    apply_stimulus(1, 0, 1, 0, 8'h7F, 8'h00);
    // 6+3, then 3-5, then 8+8 followed immediately by 1+1
    apply_stimulus(1, 1, 1, 0, 8'h66, 8'h33);
    apply_stimulus(1, 1, 1, 1, 8'h33, 8'h55);
    apply_stimulus(1, 1, 1, 0, 8'h88, 8'h88);
    apply_stimulus(1, 1, 1, 0, 8'h11, 8'h11);

    // Same 4-digit word gapless, then with a 3-cycle bubble between digits 2 and 3
    for (int i = 0; i < 4; i++) begin
      wa[i] = W'($urandom);
      wb[i] = W'($urandom);
    end
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) begin
        apply_stimulus(1, i == 0, i == 3, g[0], wa[i], wb[i]);
        if (g == 1 && i == 1) idle(3);
      end
    end
    idle(2);
    check_err();

    // Orphan digit while idle is dropped
    apply_stimulus(1, 0, 1, 0, 8'h12, 8'h34);
    idle(2);
    check_err();

    // Missing last: open word abandoned, new word starts fresh in subtract mode
    apply_stimulus(1, 1, 0, 0, 8'hFF, 8'hFF);
    apply_stimulus(1, 1, 0, 1, 8'h00, 8'h01);
    apply_stimulus(1, 0, 1, 0, 8'h00, 8'h00);
    idle(2);

    // Reset mid-word
    apply_stimulus(1, 1, 0, 0, 8'hFF, 8'hFF);
    idle(2);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    last_out = '{default: '0};
    m_frame  = 0;
    err_exp  = 0;
    check_err();
    @(posedge clk);
    #1 rst = 1'b1;
    check_err();
    apply_stimulus(1, 0, 1, 0, 8'h11, 8'h11);
    apply_stimulus(1, 1, 1, 0, 8'h01, 8'h01);
    idle(2);
    check_err();

    // Randomized traffic with bubbles and occasional protocol errors
    for (int n = 0; n < 600; n++) begin
      bit v, f, l;
      int k_eff;
      v = ($urandom_range(0, 3) != 0);
      f = m_frame ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 7) != 0);
      k_eff = (f || !m_frame) ? 0 : m_k;
      l = (k_eff >= 5) || ($urandom_range(0, 2) == 0);
      apply_stimulus(v, f, l, bit'($urandom_range(0, 1)), W'($urandom), W'($urandom));
    end
    idle(1);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    check_output("drain_timeout", 64'(exp_q.size()), 64'd0);
    check_err();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
